// File: rtl/heartaware_pkg.sv
// heartaware_pkg
// Shared constants and types for the heart-signal display path.
//   SAMPLE_W : width of one acquired sample
//   DEPTH    : samples per waveform bank (power of two, equals plotted width)
//   IDX_W    : width of the display column index (signal_pix)
//   PTR_W    : address width inside one bank, log2(DEPTH)
//   wb_state_t : write-bank occupancy state of waveform_buffer
package heartaware_pkg;

  localparam int SAMPLE_W = 8;
  localparam int DEPTH    = 1024;
  localparam int IDX_W    = 11;
  localparam int PTR_W    = $clog2(DEPTH);

  // FILL: write bank not yet complete; FULL: a whole bank of history exists
  // and further writes overwrite the oldest sample.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } wb_state_t;

endpackage

// File: rtl/sample_ram.sv
// sample_ram
// Simple dual-port sample memory: one synchronous write port and one
// synchronous read port with a registered output (one clock read latency).
// No reset on the array or the read register so it maps onto block RAM.
// Ports:
//   clock   : single clock for both ports
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every clock
//   rd_data : registered read data for the address of the previous clock
module sample_ram
  import heartaware_pkg::*;
#(
  parameter int ADDR_W = PTR_W + 1,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_reg;

  // Read-before-write ordering: a read and write to the same word in the
  // same cycle returns the old contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/waveform_buffer.sv
// waveform_buffer
// Ping-pong sample buffer feeding the display stage. Samples are captured
// into a circular write bank; at a frame boundary a complete bank is handed
// to the display, which reads it in time order (column 0 = oldest sample).
// Ports:
//   clock        : display-domain clock, rising edge
//   reset_n      : synchronous active-low reset
//   sample_in    : new sample, qualified by sample_valid
//   sample_valid : one-cycle write strobe
//   frame_start  : one-cycle pulse at start of vertical blanking (swap point)
//   freeze       : level; inhibits swaps so the displayed trace holds
//   rd_idx       : display column index (signal_pix)
//   rd_data      : sample for rd_idx, one clock later (display signal_in)
//   disp_valid   : high once the first bank has been handed over
//   bank_swap    : one-cycle pulse in the cycle after a swap commits
//   fill_level   : samples held in the write bank, 0..DEPTH
module waveform_buffer
  import heartaware_pkg::*;
#(
  parameter int DEPTH    = heartaware_pkg::DEPTH,
  parameter int SAMPLE_W = heartaware_pkg::SAMPLE_W,
  parameter int IDX_W    = heartaware_pkg::IDX_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                frame_start,
  input  logic                freeze,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                disp_valid,
  output logic                bank_swap,
  output logic [IDX_W-1:0]    fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(DEPTH - 1);

  wb_state_t          state_reg, state_next;
  logic               wr_bank_reg, wr_bank_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   disp_start_reg, disp_start_next;
  logic [IDX_W-1:0]   fill_level_reg, fill_level_next;
  logic               disp_valid_reg, disp_valid_next;
  logic               bank_swap_reg;
  logic               rd_mask_reg;

  logic               swap;
  logic               rd_in_range;
  logic [PTR_W-1:0]   rd_phys;
  logic [PTR_W:0]     ram_wr_addr;
  logic [PTR_W:0]     ram_rd_addr;
  logic [SAMPLE_W-1:0] ram_rd_data;

  // A swap needs a complete bank, a blanking pulse and no freeze.
  assign swap = frame_start && (state_reg == ST_FULL) && !freeze;

  // Next-state and pointer logic.
  always_comb begin
    state_next      = state_reg;
    wr_bank_next    = wr_bank_reg;
    wr_ptr_next     = wr_ptr_reg;
    disp_start_next = disp_start_reg;
    fill_level_next = fill_level_reg;
    disp_valid_next = disp_valid_reg;

    if (swap) begin
      state_next      = ST_FILL;
      wr_bank_next    = ~wr_bank_reg;
      // Write pointer points at the oldest sample of a full circular bank.
      disp_start_next = wr_ptr_reg;
      disp_valid_next = 1'b1;
      // A coincident sample becomes index 0 of the new write bank.
      if (sample_valid) begin
        wr_ptr_next     = PTR_W'(1);
        fill_level_next = IDX_W'(1);
      end else begin
        wr_ptr_next     = '0;
        fill_level_next = '0;
      end
    end else if (sample_valid) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (state_reg == ST_FILL) begin
        fill_level_next = fill_level_reg + IDX_W'(1);
        if (fill_level_reg == FILL_LAST) begin
          state_next = ST_FULL;
        end
      end
    end
  end

  // During a committing swap the write already targets the new bank.
  assign ram_wr_addr = swap ? {~wr_bank_reg, {PTR_W{1'b0}}}
                            : {wr_bank_reg, wr_ptr_reg};

  // Display reads rotate by disp_start so column 0 is the oldest sample.
  assign rd_phys     = disp_start_reg + rd_idx[PTR_W-1:0];
  assign ram_rd_addr = {~wr_bank_reg, rd_phys};
  assign rd_in_range = (rd_idx < DEPTH_IDX);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= ST_FILL;
      wr_bank_reg    <= 1'b0;
      wr_ptr_reg     <= '0;
      disp_start_reg <= '0;
      fill_level_reg <= '0;
      disp_valid_reg <= 1'b0;
      bank_swap_reg  <= 1'b0;
      rd_mask_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_bank_reg    <= wr_bank_next;
      wr_ptr_reg     <= wr_ptr_next;
      disp_start_reg <= disp_start_next;
      fill_level_reg <= fill_level_next;
      disp_valid_reg <= disp_valid_next;
      bank_swap_reg  <= swap;
      // Mask travels alongside the RAM read so it lines up with its data.
      rd_mask_reg    <= rd_in_range && disp_valid_reg;
    end
  end

  sample_ram #(
    .ADDR_W (PTR_W + 1),
    .DATA_W (SAMPLE_W)
  ) u_sample_ram (
    .clock   (clock),
    .wr_en   (sample_valid),
    .wr_addr (ram_wr_addr),
    .wr_data (sample_in),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // RAM is never cleared; stale or out-of-range data is masked to zero.
  assign rd_data    = rd_mask_reg ? ram_rd_data : '0;
  assign disp_valid = disp_valid_reg;
  assign bank_swap  = bank_swap_reg;
  assign fill_level = fill_level_reg;

endmodule

// File: tb/tb_waveform_buffer.sv
// tb_waveform_buffer
// Directed testbench for waveform_buffer with hand-computed expectations.
module tb_waveform_buffer;

  localparam int DEPTH    = 1024;
  localparam int SAMPLE_W = 8;
  localparam int IDX_W    = 11;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                sample_valid = 1'b0;
  logic                frame_start = 1'b0;
  logic                freeze = 1'b0;
  logic [IDX_W-1:0]    rd_idx = '0;
  logic [SAMPLE_W-1:0] rd_data;
  logic                disp_valid;
  logic                bank_swap;
  logic [IDX_W-1:0]    fill_level;

  int checks = 0;
  int errors = 0;

  waveform_buffer #(
    .DEPTH    (DEPTH),
    .SAMPLE_W (SAMPLE_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .frame_start  (frame_start),
    .freeze       (freeze),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data),
    .disp_valid   (disp_valid),
    .bank_swap    (bank_swap),
    .fill_level   (fill_level)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Writes n samples with value base + step*i (truncated to SAMPLE_W).
  task automatic write_ramp(input int n, input int base_val, input int step);
    for (int i = 0; i < n; i++) begin
      sample_in    = SAMPLE_W'(base_val + step * i);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  // One-cycle frame_start pulse with the given freeze level.
  task automatic frame(input logic frz);
    freeze      = frz;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    $display("frame_start freeze=%0b -> bank_swap=%0b disp_valid=%0b fill=%0d",
             frz, bank_swap, disp_valid, fill_level);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (rd_data !== 8'd0) begin
      errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data);
    end
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_disp_valid: got %0b expected 0", disp_valid);
    end
    checks++;
    if (bank_swap !== 1'b0) begin
      errors++; $display("FAIL reset_bank_swap: got %0b expected 0", bank_swap);
    end
    checks++;
    if (fill_level !== 11'd0) begin
      errors++; $display("FAIL reset_fill_level: got %0d expected 0", fill_level);
    end
    reset_n = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_partial_fill();
    write_ramp(DEPTH - 1, 0, 1);
    checks++;
    if (fill_level !== 11'd1023) begin
      errors++; $display("FAIL partial_fill_level: got %0d expected 1023", fill_level);
    end
    frame(1'b0);
    checks++;
    if (bank_swap !== 1'b0) begin
      errors++; $display("FAIL partial_no_swap: got %0b expected 0", bank_swap);
    end
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++; $display("FAIL partial_disp_valid: got %0b expected 0", disp_valid);
    end
    checks++;
    if (fill_level !== 11'd1023) begin
      errors++; $display("FAIL partial_fill_kept: got %0d expected 1023", fill_level);
    end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      rd_idx = IDX_W'(i);
      tick();
      checks++;
      if (rd_data !== 8'd0) begin
        errors++; $display("FAIL partial_masked_read idx=%0d: got %0d expected 0", i, rd_data);
      end
    end
    $display("partial fill sweep done");
  endtask

  task automatic test_first_swap();
    int idx_tab [6];
    int exp_tab [6];
    idx_tab = '{5, 1023, 0, 1024, 2047, 6};
    exp_tab = '{5, 255, 0, 0, 0, 6};
    write_ramp(1, 255, 0);
    checks++;
    if (fill_level !== 11'd1024) begin
      errors++; $display("FAIL first_fill_full: got %0d expected 1024", fill_level);
    end
    frame(1'b0);
    checks++;
    if (bank_swap !== 1'b1) begin
      errors++; $display("FAIL first_bank_swap: got %0b expected 1", bank_swap);
    end
    checks++;
    if (disp_valid !== 1'b1) begin
      errors++; $display("FAIL first_disp_valid: got %0b expected 1", disp_valid);
    end
    checks++;
    if (fill_level !== 11'd0) begin
      errors++; $display("FAIL first_fill_cleared: got %0d expected 0", fill_level);
    end
    tick();
    checks++;
    if (bank_swap !== 1'b0) begin
      errors++; $display("FAIL first_bank_swap_pulse: got %0b expected 0", bank_swap);
    end
    for (int k = 0; k < 6; k++) begin
      rd_idx = IDX_W'(idx_tab[k]);
      tick();
      $display("read idx=%0d data=%0d", idx_tab[k], rd_data);
      checks++;
      if (rd_data !== SAMPLE_W'(exp_tab[k])) begin
        errors++; $display("FAIL first_read idx=%0d: got %0d expected %0d", idx_tab[k], rd_data, exp_tab[k]);
      end
    end
  endtask

  task automatic test_wrap_1100();
    int idx_tab [4];
    int exp_tab [4];
    idx_tab = '{0, 1023, 5, 947};
    exp_tab = '{76, 75, 81, 255};
    write_ramp(1100, 0, 1);
    checks++;
    if (fill_level !== 11'd1024) begin
      errors++; $display("FAIL wrap_fill_saturate: got %0d expected 1024", fill_level);
    end
    // The display bank must still hold the previous frame.
    rd_idx = 11'd5;
    tick();
    checks++;
    if (rd_data !== 8'd5) begin
      errors++; $display("FAIL wrap_display_held: got %0d expected 5", rd_data);
    end
    frame(1'b0);
    checks++;
    if (bank_swap !== 1'b1) begin
      errors++; $display("FAIL wrap_bank_swap: got %0b expected 1", bank_swap);
    end
    for (int k = 0; k < 4; k++) begin
      rd_idx = IDX_W'(idx_tab[k]);
      tick();
      $display("read idx=%0d data=%0d", idx_tab[k], rd_data);
      checks++;
      if (rd_data !== SAMPLE_W'(exp_tab[k])) begin
        errors++; $display("FAIL wrap_read idx=%0d: got %0d expected %0d", idx_tab[k], rd_data, exp_tab[k]);
      end
    end
  endtask

  task automatic test_freeze();
    int idx_tab [4];
    int exp_tab [4];
    idx_tab = '{0, 1, 1023, 300};
    exp_tab = '{255, 254, 0, 211};
    write_ramp(DEPTH, 255, -1);
    frame(1'b1);
    checks++;
    if (bank_swap !== 1'b0) begin
      errors++; $display("FAIL freeze_no_swap: got %0b expected 0", bank_swap);
    end
    checks++;
    if (fill_level !== 11'd1024) begin
      errors++; $display("FAIL freeze_fill_kept: got %0d expected 1024", fill_level);
    end
    rd_idx = 11'd0;
    tick();
    checks++;
    if (rd_data !== 8'd76) begin
      errors++; $display("FAIL freeze_display_held0: got %0d expected 76", rd_data);
    end
    rd_idx = 11'd1023;
    tick();
    checks++;
    if (rd_data !== 8'd75) begin
      errors++; $display("FAIL freeze_display_held1023: got %0d expected 75", rd_data);
    end
    frame(1'b0);
    checks++;
    if (bank_swap !== 1'b1) begin
      errors++; $display("FAIL unfreeze_swap: got %0b expected 1", bank_swap);
    end
    for (int k = 0; k < 4; k++) begin
      rd_idx = IDX_W'(idx_tab[k]);
      tick();
      $display("read idx=%0d data=%0d", idx_tab[k], rd_data);
      checks++;
      if (rd_data !== SAMPLE_W'(exp_tab[k])) begin
        errors++; $display("FAIL unfreeze_read idx=%0d: got %0d expected %0d", idx_tab[k], rd_data, exp_tab[k]);
      end
    end
  endtask

  task automatic test_coincident();
    int idx_tab [3];
    int exp_tab [3];
    idx_tab = '{0, 1, 1023};
    exp_tab = '{171, 17, 17};
    write_ramp(DEPTH, 0, 1);
    sample_in    = 8'hAB;
    sample_valid = 1'b1;
    frame_start  = 1'b1;
    tick();
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    $display("coincident sample+swap -> bank_swap=%0b fill=%0d", bank_swap, fill_level);
    checks++;
    if (bank_swap !== 1'b1) begin
      errors++; $display("FAIL coincident_swap: got %0b expected 1", bank_swap);
    end
    checks++;
    if (fill_level !== 11'd1) begin
      errors++; $display("FAIL coincident_fill: got %0d expected 1", fill_level);
    end
    rd_idx = 11'd1023;
    tick();
    checks++;
    if (rd_data !== 8'd255) begin
      errors++; $display("FAIL coincident_disp_read: got %0d expected 255", rd_data);
    end
    write_ramp(DEPTH - 1, 17, 0);
    frame(1'b0);
    checks++;
    if (bank_swap !== 1'b1) begin
      errors++; $display("FAIL coincident_second_swap: got %0b expected 1", bank_swap);
    end
    for (int k = 0; k < 3; k++) begin
      rd_idx = IDX_W'(idx_tab[k]);
      tick();
      $display("read idx=%0d data=%0d", idx_tab[k], rd_data);
      checks++;
      if (rd_data !== SAMPLE_W'(exp_tab[k])) begin
        errors++; $display("FAIL coincident_read idx=%0d: got %0d expected %0d", idx_tab[k], rd_data, exp_tab[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    write_ramp(100, 0, 1);
    checks++;
    if (fill_level !== 11'd100) begin
      errors++; $display("FAIL midreset_fill_before: got %0d expected 100", fill_level);
    end
    reset_n = 1'b0;
    rd_idx  = 11'd0;
    tick();
    $display("mid-fill reset -> fill=%0d disp_valid=%0b", fill_level, disp_valid);
    checks++;
    if (fill_level !== 11'd0) begin
      errors++; $display("FAIL midreset_fill: got %0d expected 0", fill_level);
    end
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_disp_valid: got %0b expected 0", disp_valid);
    end
    checks++;
    if (rd_data !== 8'd0) begin
      errors++; $display("FAIL midreset_rd_data: got %0d expected 0", rd_data);
    end
    reset_n = 1'b1;
    rd_idx  = 11'd1;
    tick();
    checks++;
    if (rd_data !== 8'd0) begin
      errors++; $display("FAIL postreset_masked: got %0d expected 0", rd_data);
    end
    frame(1'b0);
    checks++;
    if (bank_swap !== 1'b0) begin
      errors++; $display("FAIL postreset_no_swap: got %0b expected 0", bank_swap);
    end
  endtask

  initial begin
    test_reset();
    test_partial_fill();
    test_first_swap();
    test_wrap_1100();
    test_freeze();
    test_coincident();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
